// File: rtl/srt_prenorm_pkg.sv
// Shared definitions for the SRT divider pre-normalization stage:
// FSM state encoding and the normalized-divisor format bounds.
package srt_prenorm_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_NORM  = 3'd1;
  localparam logic [2:0] S_CLR   = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_NORM  = S_NORM,
    ST_CLR   = S_CLR,
    ST_START = S_START,
    ST_WAIT  = S_WAIT,
    ST_FIN   = S_FIN
  } state_t;

  // Quotient-select table accepts divisors in [D_MIN, D_MAX].
  localparam logic [5:0] D_MIN = 6'b010000;
  localparam logic [5:0] D_MAX = 6'b100000;

  function automatic logic d_in_format(input logic [5:0] d);
    return (d >= D_MIN) && (d <= D_MAX);
  endfunction

  // Dividend must stay below 4*D so the radix-4 recurrence starts in range.
  function automatic logic dividend_in_range(input logic [7:0] n, input logic [5:0] d);
    return n < {d, 2'b00};
  endfunction

endpackage

// File: rtl/srt_lzc_shift.sv
// Divisor normalizer: shifts the loaded value left one bit per step until
// its MSB is set, counting the shifts applied.
module srt_lzc_shift #(
  parameter int W  = 5,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load,
  input  logic [W-1:0]  load_val,
  input  logic          step,
  output logic [W-1:0]  norm_val,
  output logic [CW-1:0] shift_cnt
);

  logic [W-1:0]  norm_reg;
  logic [CW-1:0] shift_reg;
  logic [W-1:0]  shifted;

  assign shifted[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < W; gi++) begin : g_shl
      assign shifted[gi] = norm_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      norm_reg  <= '0;
      shift_reg <= '0;
    end else if (load) begin
      norm_reg  <= load_val;
      shift_reg <= '0;
    end else if (step && !norm_reg[W-1]) begin
      norm_reg  <= shifted;
      shift_reg <= shift_reg + CW'(1);
    end
  end

  assign norm_val  = norm_reg;
  assign shift_cnt = shift_reg;

endmodule

// File: rtl/srt_prenorm.sv
// Front end of the radix-4 SRT divider: accepts operands, normalizes the
// divisor, range-checks the dividend, restarts and launches the divider.
module srt_prenorm
  import srt_prenorm_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 15,
  parameter int NORM_W       = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        dividend,
  input  logic [NORM_W-1:0] divisor,
  output logic [7:0]        div_N,
  output logic [NORM_W:0]   div_D,
  output logic              div_resetn,
  output logic              div_enable,
  input  logic              div_done,
  output logic [2:0]        norm_shift,
  output logic              op_done,
  output logic              div0_err,
  output logic              range_err,
  output logic              timeout_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic [7:0]        div_n_reg;
  logic [NORM_W:0]   div_d_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              armed_reg;
  logic              div0_err_reg, range_err_reg, timeout_err_reg;
  logic              div0_err_next, range_err_next, timeout_err_next;
  logic              lzc_load, lzc_step;
  logic [NORM_W-1:0] lzc_norm;
  logic [2:0]        lzc_shift;
  logic [NORM_W:0]   d_candidate;
  logic              d_ready;
  logic              n_in_range;

  srt_lzc_shift #(
    .W  (NORM_W),
    .CW (3)
  ) u_lzc (
    .clk       (clk),
    .resetn    (resetn),
    .load      (lzc_load),
    .load_val  (divisor),
    .step      (lzc_step),
    .norm_val  (lzc_norm),
    .shift_cnt (lzc_shift)
  );

  assign d_candidate = {1'b0, lzc_norm};
  assign d_ready     = d_in_format(d_candidate);
  assign n_in_range  = dividend_in_range(div_n_reg, div_d_reg);

  always_comb begin
    state_next       = state_reg;
    lzc_load         = 1'b0;
    lzc_step         = 1'b0;
    div0_err_next    = 1'b0;
    range_err_next   = 1'b0;
    timeout_err_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            div0_err_next = 1'b1;
          end else begin
            lzc_load   = 1'b1;
            state_next = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        if (d_ready) state_next = ST_CLR;
        else         lzc_step   = 1'b1;
      end
      ST_CLR: begin
        if (!n_in_range) begin
          range_err_next = 1'b1;
          state_next     = ST_IDLE;
        end else begin
          state_next = ST_START;
        end
      end
      ST_START: state_next = ST_WAIT;
      ST_WAIT: begin
        // A done arriving on the last counted cycle still counts as success.
        if (div_done) begin
          state_next = ST_FIN;
        end else if (cnt_reg == CNT_LAST) begin
          timeout_err_next = 1'b1;
          state_next       = ST_IDLE;
        end
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= ST_IDLE;
      div_n_reg       <= '0;
      div_d_reg       <= '0;
      cnt_reg         <= '0;
      armed_reg       <= 1'b0;
      div0_err_reg    <= 1'b0;
      range_err_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      armed_reg       <= 1'b1;
      div0_err_reg    <= div0_err_next;
      range_err_reg   <= range_err_next;
      timeout_err_reg <= timeout_err_next;
      if (lzc_load) div_n_reg <= dividend;
      if (state_reg == ST_NORM && d_ready) div_d_reg <= d_candidate;
      if (state_reg == ST_START)     cnt_reg <= '0;
      else if (state_reg == ST_WAIT) cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // The divider's STOP state is terminal, so every launch is preceded by one
  // synchronous-reset cycle in CLR; armed_reg keeps it in reset until the
  // first clock after our own reset releases.
  assign div_resetn  = armed_reg && !(state_reg == ST_CLR && n_in_range);
  assign div_enable  = (state_reg == ST_START);
  assign in_ready    = (state_reg == ST_IDLE);
  assign busy        = (state_reg != ST_IDLE);
  assign op_done     = (state_reg == ST_FIN);
  assign div0_err    = div0_err_reg;
  assign range_err   = range_err_reg;
  assign timeout_err = timeout_err_reg;
  assign div_N       = div_n_reg;
  assign div_D       = div_d_reg;
  assign norm_shift  = lzc_shift;

endmodule

// File: tb/tb_srt_prenorm.sv
// Self-checking bench for srt_prenorm: directed and random operand requests
// against a transaction-level model plus a behavioural divider stub.
`timescale 1ns/1ps
module tb_srt_prenorm;

  localparam int WAIT_TIMEOUT = 15;
  localparam int DIV_LAT      = 6;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [4:0] divisor;
  logic [7:0] div_N;
  logic [5:0] div_D;
  logic       div_resetn;
  logic       div_enable;
  logic       div_done;
  logic [2:0] norm_shift;
  logic       op_done, div0_err, range_err, timeout_err, busy;

  bit         hang;
  bit         dv_run;
  int         dv_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Values the block must be holding on its outputs after the last accept.
  int exp_n = 0, exp_d = 0, exp_k = 0;

  srt_prenorm #(
    .WAIT_TIMEOUT (WAIT_TIMEOUT),
    .NORM_W       (5)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .div_N       (div_N),
    .div_D       (div_D),
    .div_resetn  (div_resetn),
    .div_enable  (div_enable),
    .div_done    (div_done),
    .norm_shift  (norm_shift),
    .op_done     (op_done),
    .div0_err    (div0_err),
    .range_err   (range_err),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Divider stub: terminal STOP (done held) until a synchronous reset;
  // WAIT lasts DIV_LAT cycles after enable is sampled.
  always @(posedge clk) begin
    if (!div_resetn) begin
      div_done <= 1'b0;
      dv_run   <= 1'b0;
      dv_cnt   <= 0;
    end else if (dv_run) begin
      if (dv_cnt == DIV_LAT - 1) begin
        div_done <= 1'b1;
        dv_run   <= 1'b0;
      end else begin
        dv_cnt <= dv_cnt + 1;
      end
    end else if (div_enable && !div_done && !hang) begin
      dv_run <= 1'b1;
      dv_cnt <= 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_idle_reset_values(input string tag);
    check_val({tag, "_in_ready"},   32'(in_ready), 1);
    check_val({tag, "_busy"},       32'(busy), 0);
    check_val({tag, "_div_resetn"}, 32'(div_resetn), 0);
    check_val({tag, "_div_enable"}, 32'(div_enable), 0);
    check_val({tag, "_div_N"},      32'(div_N), 0);
    check_val({tag, "_div_D"},      32'(div_D), 0);
    check_val({tag, "_norm_shift"}, 32'(norm_shift), 0);
    check_val({tag, "_pulses"},
              32'(int'(op_done) + int'(div0_err) + int'(range_err) + int'(timeout_err)), 0);
  endtask

  // kind: 0 op_done, 1 div0_err, 2 range_err, 3 timeout_err
  task automatic run_op(input logic [7:0] n, input logic [4:0] d, input bit hang_i, input bit hold);
    int   kind, exp_off, k, v;
    int   rl_cnt, en_cnt, pulse_cnt, busy_bad, pulses;
    int   got_kind, got_off, evt_n, evt_d, evt_k, evt_ready;
    bit   launched;
    hang = hang_i;
    k = 0;
    if (d == 0) begin
      kind = 1; exp_off = 1; launched = 0;
    end else begin
      v = int'(d);
      while (v < 16) begin v = v * 2; k++; end
      exp_n = int'(n); exp_d = v; exp_k = k;
      if (int'(n) >= 4 * v) begin
        kind = 2; exp_off = k + 3; launched = 0;
      end else if (hang_i) begin
        kind = 3; exp_off = k + 4 + WAIT_TIMEOUT; launched = 1;
      end else begin
        kind = 0; exp_off = k + 4 + DIV_LAT; launched = 1;
      end
    end

    @(negedge clk);
    check_val("ready_before_accept", 32'(in_ready), 1);
    dividend = n; divisor = d; in_valid = 1'b1;
    rl_cnt = 0; en_cnt = 0; pulse_cnt = 0; busy_bad = 0;
    got_kind = -1; got_off = 0; evt_n = 0; evt_d = 0; evt_k = 0; evt_ready = 0;

    for (int off = 1; off <= 60; off++) begin
      @(negedge clk);
      if (!div_resetn) rl_cnt++;
      if (div_enable) en_cnt++;
      pulses = int'(op_done) + int'(div0_err) + int'(range_err) + int'(timeout_err);
      pulse_cnt += pulses;
      if (got_kind < 0 && pulses != 0) begin
        got_kind  = op_done ? 0 : div0_err ? 1 : range_err ? 2 : 3;
        got_off   = off;
        evt_n     = int'(div_N);
        evt_d     = int'(div_D);
        evt_k     = int'(norm_shift);
        evt_ready = int'(in_ready);
      end else if (got_kind < 0 && kind != 1 && (in_ready || !busy)) begin
        busy_bad++;
      end
      if (!hold || got_kind >= 0) in_valid = 1'b0;
      if (got_kind >= 0 && off > got_off) break;
    end
    in_valid = 1'b0;

    $display("op n=%0d d=%0d hang=%0d hold=%0d -> kind=%0d at %0d (model kind=%0d at %0d) N=%0d D=%0d k=%0d",
             n, d, hang_i, hold, got_kind, got_off, kind, exp_off, evt_n, evt_d, evt_k);
    check_val("event_kind",      32'(got_kind), 32'(kind));
    check_val("event_offset",    32'(got_off), 32'(exp_off));
    check_val("pulse_cycles",    32'(pulse_cnt), 1);
    check_val("div_resetn_lows", 32'(rl_cnt), launched ? 1 : 0);
    check_val("enable_cycles",   32'(en_cnt), launched ? 1 : 0);
    check_val("ready_while_busy", 32'(busy_bad), 0);
    check_val("ready_at_event",  32'(evt_ready), (kind == 0) ? 0 : 1);
    check_val("div_N_at_event",  32'(evt_n), 32'(exp_n));
    check_val("div_D_at_event",  32'(evt_d), 32'(exp_d));
    check_val("shift_at_event",  32'(evt_k), 32'(exp_k));
    hang = 1'b0;
  endtask

  task automatic reset_mid_wait();
    hang = 1'b1;
    @(negedge clk);
    dividend = 8'h20; divisor = 5'b10110; in_valid = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    check_val("busy_before_reset", 32'(busy), 1);
    #2 resetn = 1'b0;
    #1;
    $display("async reset asserted during WAIT");
    check_idle_reset_values("midrst");
    exp_n = 0; exp_d = 0; exp_k = 0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check_val("rel_div_resetn", 32'(div_resetn), 1);
    check_val("rel_in_ready",   32'(in_ready), 1);
    hang = 1'b0;
  endtask

  initial begin
    logic [7:0] rn;
    logic [4:0] rd;
    resetn = 1'b0; in_valid = 1'b0; dividend = '0; divisor = '0; hang = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_reset_values("reset");
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check_val("first_clk_div_resetn", 32'(div_resetn), 1);

    run_op(8'h40, 5'b10110, 1'b0, 1'b0);
    run_op(8'h10, 5'b00011, 1'b0, 1'b1);
    run_op(8'h33, 5'b00000, 1'b0, 1'b0);
    run_op(8'h40, 5'b10000, 1'b0, 1'b0);
    run_op(8'h3F, 5'b10000, 1'b0, 1'b0);
    run_op(8'h20, 5'b00101, 1'b1, 1'b0);
    run_op(8'h25, 5'b01001, 1'b0, 1'b0);
    run_op(8'h07, 5'b00001, 1'b0, 1'b1);
    reset_mid_wait();
    run_op(8'h12, 5'b00000, 1'b0, 1'b1);
    run_op(8'h30, 5'b11111, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rn = 8'($urandom_range(0, 140));
      run_op(rn, rd, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/srt_prenorm.md
Name: srt_prenorm

Overview:
- Upstream stage of the radix-4 SRT divider core.
- Accepts a raw dividend and divisor over a valid/ready handshake, left-normalizes the divisor into the 6-bit 01xxxx / 100000 format the divider's quotient-select table requires, and range-checks the dividend.
- Re-arms the divider through its synchronous reset, launches it with enable, then waits for its done and reports completion or error.
- The divider's STOP state is terminal, so this block owns the divider's restart sequence.

Parameters:
- WAIT_TIMEOUT, 15: maximum cycles in WAIT before a timeout error is raised.
- NORM_W, 5: raw divisor width; the normalized divisor is {1'b0, norm_reg}.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE.
- dividend  in  8  raw dividend.
- divisor  in  5  raw divisor; must be nonzero.
- div_N  out  8  dividend to divider; stable from CLR through WAIT.
- div_D  out  6  normalized divisor to divider; stable from CLR through WAIT.
- div_resetn  out  1  synchronous active-low restart to divider.
- div_enable  out  1  divider start.
- div_done  in  1  divider done (level, held until its next reset).
- norm_shift  out  3  left-shift count k applied to the divisor (0..4); quotient is scaled by 2^k.
- op_done  out  1  one-cycle pulse: divider result valid.
- div0_err  out  1  one-cycle pulse: divisor == 0.
- range_err  out  1  one-cycle pulse: dividend out of range.
- timeout_err  out  1  one-cycle pulse: div_done not seen within WAIT_TIMEOUT.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, resetn=0) values:
  - state=IDLE; in_ready=1; busy=0.
  - div_resetn=0 (divider held in reset); div_enable=0.
  - All pulses 0; div_N=0, div_D=0, norm_shift=0; timeout counter=0.
- Deassertion: the first clock after resetn rises drives div_resetn=1.
- States: IDLE, NORM, CLR, START, WAIT, FIN.
- IDLE:
  - Accept on in_valid && in_ready.
  - If divisor==0: pulse div0_err next cycle, stay in IDLE, no launch.
  - Otherwise latch dividend into div_N and divisor into norm_reg, set norm_shift=0, go to NORM.
- NORM:
  - If norm_reg[4]==0: shift norm_reg left by 1 and increment norm_shift; one bit per cycle.
  - If norm_reg[4]==1: div_D={1'b0,norm_reg}, go to CLR.
  - Latency is k+1 cycles, k = leading zeros of the divisor (0..4).
- CLR:
  - If div_N >= {div_D,2'b00} (8-bit unsigned compare): pulse range_err, return to IDLE, no launch.
  - Otherwise drive div_resetn=0 for exactly this one cycle, go to START.
- START: div_enable=1 for one cycle (the divider samples enable in its IDLE); go to WAIT and clear the counter.
- WAIT:
  - div_enable=0; counter increments each cycle.
  - On div_done==1: go to FIN.
  - On counter==WAIT_TIMEOUT-1 without div_done: pulse timeout_err, go to IDLE.
  - If both occur in the same cycle, done wins.
- FIN: op_done=1 for one cycle; norm_shift and div_N/div_D are held; go to IDLE.
- Output hold:
  - div_N, div_D and norm_shift hold their values in IDLE until the next accept.
  - div_done is ignored outside WAIT.
- Nominal latency, accept to op_done, with a 6-cycle divider: k+1 (NORM) + 1 (CLR) + 1 (START) + 6 (divider) + 1 (FIN).
- in_valid while busy is ignored; no queuing.
- Reset mid-operation: immediate return to IDLE, and the divider is held in reset via div_resetn.

Decomposition:
- Shared package holds the state encoding (3-bit localparams for IDLE..FIN) and the D format constants D_MIN=6'b010000, D_MAX=6'b100000.
- One sub-module is natural: srt_lzc_shift, the normalization shifter/counter. Everything else stays in one FSM module.

Test Plan:
- Divisor 5'b10110, dividend 8'h40 -> k=0, div_D=6'b010110, one div_resetn low cycle, then one enable cycle; with a divider model asserting done 6 cycles later -> op_done pulse, norm_shift=0.
- Divisor 5'b00011, dividend 8'h10 -> 3 shift cycles, then div_D=6'b011000, norm_shift=3, launch, op_done.
- Divisor 0 -> div0_err single pulse, div_resetn stays 1, div_enable never rises, in_ready stays 1.
- Divisor 5'b10000 (div_D=6'b010000), dividend 8'h40 -> range_err (64 >= 64), no launch; dividend 8'h3F -> launched normally.
- Divider model never asserts done -> timeout_err exactly WAIT_TIMEOUT cycles after START, then back to IDLE and a new accept works.
- resetn pulsed low during WAIT -> outputs return to reset values asynchronously; in_valid held during busy is never accepted twice.
